// File: rtl/riot_param_if.sv
// Host bus for riot_param: chip/RAM select, strobes, address, data and interrupt.
interface riot_param_if;
    logic       cs_n;
    logic       rs_n;
    logic       we_n;
    logic [6:0] A;
    logic [7:0] DI;
    logic [7:0] DO;
    logic       OE;
    logic       irq_n;

    modport master (output cs_n, rs_n, we_n, A, DI, input DO, OE, irq_n);
    modport slave  (input cs_n, rs_n, we_n, A, DI, output DO, OE, irq_n);
endinterface

// File: rtl/riot_param.sv
// RAM / I/O / timer combo: byte RAM, NPORTS bidirectional 8-bit ports,
// prescaled 8-bit interval timer and PI[7] edge detector with a shared interrupt.
module riot_param #(
    parameter int unsigned NPORTS         = 2,
    parameter int unsigned RAM_AW         = 7,
    parameter int unsigned TIMER_FREE_RUN = 1
) (
    input  logic                phi2,
    input  logic                rst_n,
    riot_param_if.slave         bus,
    output logic [8*NPORTS-1:0] PO,
    input  logic [8*NPORTS-1:0] PI,
    output logic [8*NPORTS-1:0] DDR
);

    localparam int unsigned PW        = 8 * NPORTS;
    localparam int unsigned RAM_DEPTH = 1 << RAM_AW;
    localparam int unsigned PSC_W     = 10;

    logic [7:0]       r_ram [RAM_DEPTH];

    logic [PW-1:0]    r_po,  w_po_nxt;
    logic [PW-1:0]    r_ddr, w_ddr_nxt;
    logic [7:0]       r_timer, w_timer_nxt;
    logic [1:0]       r_sel, w_sel_nxt;
    logic [PSC_W-1:0] r_presc, w_presc_nxt;
    logic             r_run, w_run_nxt;
    logic             r_free, w_free_nxt;
    logic             r_tirq_en, w_tirq_en_nxt;
    logic             r_tflag, w_tflag_nxt;
    logic             r_eflag, w_eflag_nxt;
    logic             r_een, w_een_nxt;
    logic             r_epol, w_epol_nxt;
    logic             r_pi7, r_pi7_vld;
    logic [7:0]       r_do;
    logic             r_oe;
    logic             r_irq_n;

    logic             w_sel, w_rd, w_wr;
    logic             w_ram, w_pspace, w_tspace, w_espace;
    logic [7:0]       w_rdata, w_pdat;
    logic [PSC_W-1:0] w_lim;
    logic             w_tick, w_tset, w_edge;

    // Address decode
    assign w_sel    = ~bus.cs_n;
    assign w_rd     = w_sel &  bus.we_n;
    assign w_wr     = w_sel & ~bus.we_n;
    assign w_ram    = w_sel & ~bus.rs_n;
    assign w_pspace = w_sel &  bus.rs_n & (bus.A[5:4] == 2'b00);
    assign w_tspace = w_sel &  bus.rs_n & (bus.A[5:4] == 2'b01);
    assign w_espace = w_sel &  bus.rs_n & (bus.A[5:4] == 2'b10);

    // RAM is deliberately outside the reset domain so contents survive rst_n
    always_ff @(posedge phi2) begin
        if (w_wr && w_ram) begin
            r_ram[bus.A[RAM_AW-1:0]] <= bus.DI;
        end
    end

    // Port read view: output bits show PO, input bits show the pins
    always_comb begin
        w_pdat = 8'h00;
        for (int unsigned p = 0; p < NPORTS; p++) begin
            if (bus.A[3:1] == 3'(p)) begin
                w_pdat = bus.A[0] ? r_ddr[8*p +: 8]
                                  : ((r_po[8*p +: 8] & r_ddr[8*p +: 8]) |
                                     (PI[8*p +: 8]   & ~r_ddr[8*p +: 8]));
            end
        end
    end

    always_comb begin
        w_rdata = 8'h00;
        if (w_ram) begin
            w_rdata = r_ram[bus.A[RAM_AW-1:0]];
        end else if (w_pspace) begin
            w_rdata = w_pdat;
        end else if (w_tspace) begin
            w_rdata = bus.A[0] ? {r_tflag, r_eflag, 6'b0} : r_timer;
        end
    end

    always_comb begin
        w_po_nxt  = r_po;
        w_ddr_nxt = r_ddr;
        for (int unsigned p = 0; p < NPORTS; p++) begin
            if (w_wr && w_pspace && (bus.A[3:1] == 3'(p))) begin
                if (bus.A[0]) begin
                    w_ddr_nxt[8*p +: 8] = bus.DI;
                end else begin
                    w_po_nxt[8*p +: 8] = bus.DI;
                end
            end
        end
    end

    // Prescale terminal count; forced to 1 clock while free-running after underflow
    always_comb begin
        case (r_sel)
            2'b00:   w_lim = PSC_W'(0);
            2'b01:   w_lim = PSC_W'(7);
            2'b10:   w_lim = PSC_W'(63);
            default: w_lim = PSC_W'(1023);
        endcase
        if (r_free) begin
            w_lim = PSC_W'(0);
        end
    end

    assign w_tick = r_run & (r_presc == w_lim);
    assign w_edge = r_pi7_vld & (r_epol ? (~r_pi7 &  PI[7])
                                        : ( r_pi7 & ~PI[7]));

    // Timer, flags and enables; a flag set beats a same-cycle clear, a timer write beats both
    always_comb begin
        w_timer_nxt   = r_timer;
        w_sel_nxt     = r_sel;
        w_presc_nxt   = r_presc;
        w_run_nxt     = r_run;
        w_free_nxt    = r_free;
        w_tirq_en_nxt = r_tirq_en;
        w_tflag_nxt   = r_tflag;
        w_eflag_nxt   = r_eflag;
        w_een_nxt     = r_een;
        w_epol_nxt    = r_epol;
        w_tset        = 1'b0;

        if (w_tick) begin
            w_presc_nxt = PSC_W'(0);
            if (r_timer == 8'h00) begin
                w_tset = 1'b1;
                if (TIMER_FREE_RUN != 0) begin
                    w_timer_nxt = 8'hFF;
                    w_free_nxt  = 1'b1;
                end else begin
                    w_run_nxt = 1'b0;
                end
            end else begin
                w_timer_nxt = r_timer - 8'd1;
            end
        end else if (r_run) begin
            w_presc_nxt = r_presc + PSC_W'(1);
        end

        if (w_rd && w_tspace) begin
            if (bus.A[0]) begin
                w_eflag_nxt = 1'b0;
            end else begin
                w_tirq_en_nxt = bus.A[2];
                w_tflag_nxt   = 1'b0;
            end
        end

        if (w_tset) w_tflag_nxt = 1'b1;
        if (w_edge) w_eflag_nxt = 1'b1;

        if (w_wr && w_tspace) begin
            w_timer_nxt   = bus.DI;
            w_sel_nxt     = bus.A[1:0];
            w_tirq_en_nxt = bus.A[2];
            w_tflag_nxt   = 1'b0;
            w_presc_nxt   = PSC_W'(0);
            w_run_nxt     = 1'b1;
            w_free_nxt    = 1'b0;
        end

        if (w_wr && w_espace) begin
            w_een_nxt  = bus.A[1];
            w_epol_nxt = bus.A[0];
        end
    end

    always_ff @(posedge phi2 or negedge rst_n) begin
        if (!rst_n) begin
            r_po      <= '0;
            r_ddr     <= '0;
            r_timer   <= 8'h00;
            r_sel     <= 2'b00;
            r_presc   <= '0;
            r_run     <= 1'b0;
            r_free    <= 1'b0;
            r_tirq_en <= 1'b0;
            r_tflag   <= 1'b0;
            r_eflag   <= 1'b0;
            r_een     <= 1'b0;
            r_epol    <= 1'b0;
            r_pi7     <= 1'b0;
            r_pi7_vld <= 1'b0;
            r_do      <= 8'h00;
            r_oe      <= 1'b0;
            r_irq_n   <= 1'b1;
        end else begin
            r_po      <= w_po_nxt;
            r_ddr     <= w_ddr_nxt;
            r_timer   <= w_timer_nxt;
            r_sel     <= w_sel_nxt;
            r_presc   <= w_presc_nxt;
            r_run     <= w_run_nxt;
            r_free    <= w_free_nxt;
            r_tirq_en <= w_tirq_en_nxt;
            r_tflag   <= w_tflag_nxt;
            r_eflag   <= w_eflag_nxt;
            r_een     <= w_een_nxt;
            r_epol    <= w_epol_nxt;
            r_pi7     <= PI[7];
            r_pi7_vld <= 1'b1;
            r_do      <= w_rd ? w_rdata : r_do;
            r_oe      <= w_rd;
            // Interrupt tracks the flag/enable state being registered on this edge
            r_irq_n   <= ~((w_tflag_nxt & w_tirq_en_nxt) | (w_eflag_nxt & w_een_nxt));
        end
    end

    assign PO        = r_po;
    assign DDR       = r_ddr;
    assign bus.DO    = r_do;
    assign bus.OE    = r_oe;
    assign bus.irq_n = r_irq_n;

endmodule
